// File: rtl/display_scan_ctrl_if.sv
// Host-side write/commit bus for the display scan controller.
interface display_scan_ctrl_if;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [4:0] wr_code;
    logic       commit_req;
    logic       commit_ack;

    modport master (
        output wr_en,
        output wr_idx,
        output wr_code,
        output commit_req,
        input  commit_ack
    );

    modport slave (
        input  wr_en,
        input  wr_idx,
        input  wr_code,
        input  commit_req,
        output commit_ack
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 5-input/7-segment decoder.
// Digits are lit round-robin with a blanking gap before each slot. Host writes land in
// shadow registers and are copied to the active set only at a frame boundary (or while idle).
module display_scan_ctrl #(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned SHOW_CYCLES  = 8,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    display_scan_ctrl_if.slave     bus,
    output logic [4:0]             code_out,
    output logic [N_DIGITS-1:0]    digit_en,
    output logic                   blank,
    output logic                   frame_done
);

    localparam int unsigned MaxCyc = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam int unsigned IdxW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CntW-1:0] ShowLast  = CntW'(SHOW_CYCLES - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(N_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic [4:0]        shadow_q [N_DIGITS];
    logic [4:0]        shadow_d [N_DIGITS];
    logic [4:0]        active_q [N_DIGITS];
    logic [4:0]        active_d [N_DIGITS];

    logic [4:0]          code_out_q, code_out_d;
    logic [N_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                blank_q, blank_d;
    logic                frame_done_q, frame_done_d;
    logic                commit_ack_q;
    logic                copy;

    // Scan sequencing: idle -> (blank -> show) per digit, wrapping at the last digit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StBlank;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StShow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StShow: begin
                    if (cnt_q == ShowLast) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Shadow writes, commit tracking and the shadow->active copy.
    // The copy is taken on the edge that enters the last show clock of a frame, so the
    // write and request sampled on that edge are folded into it.
    always_comb begin
        frame_done_d = (state_d == StShow) && (idx_d == IdxLast) && (cnt_d == ShowLast);
        copy         = (frame_done_d && (pending_q || bus.commit_req)) ||
                       ((state_q == StIdle) && pending_q);
        for (int i = 0; i < N_DIGITS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (bus.wr_en && (bus.wr_idx == 3'(i))) begin
                shadow_d[i] = bus.wr_code;
            end
            active_d[i] = copy ? shadow_d[i] : active_q[i];
        end
        pending_d = copy ? 1'b0 : (pending_q || bus.commit_req);
    end

    // Registered outputs follow the next state; code uses the pre-copy active set so the
    // last show clock of a frame keeps its old code.
    always_comb begin
        code_out_d = (state_d == StIdle) ? 5'd0 : active_q[idx_d];
        blank_d    = (state_d != StShow);
        for (int i = 0; i < N_DIGITS; i++) begin
            digit_en_d[i] = (state_d == StShow) && (idx_d == IdxW'(i));
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // Shadow and active code storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_q[i] <= 5'd0;
                active_q[i] <= 5'd0;
            end
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_out_q   <= 5'd0;
            digit_en_q   <= '0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
            commit_ack_q <= 1'b0;
        end else begin
            code_out_q   <= code_out_d;
            digit_en_q   <= digit_en_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
            commit_ack_q <= copy;
        end
    end

    assign code_out       = code_out_q;
    assign digit_en       = digit_en_q;
    assign blank          = blank_q;
    assign frame_done     = frame_done_q;
    assign bus.commit_ack = commit_ack_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-position reference model, directed scenarios with
// literal pins, then randomized traffic.
module tb_display_scan_ctrl;
    localparam int N = 4;
    localparam int S = 8;
    localparam int B = 2;
    localparam int F = N * (B + S);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [4:0]     code_out;
    logic [N-1:0]   digit_en;
    logic           blank;
    logic           frame_done;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(
        .N_DIGITS    (N),
        .SHOW_CYCLES (S),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bus       (bus),
        .code_out  (code_out),
        .digit_en  (digit_en),
        .blank     (blank),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: scan described by position within the frame.
    bit         m_run;
    int         m_p;
    bit         m_pend;
    logic [4:0] m_sh  [N];
    logic [4:0] m_act [N];
    logic [4:0]   e_code;
    logic [N-1:0] e_den;
    logic         e_blank, e_fd, e_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_p = 0; m_pend = 0;
        for (int i = 0; i < N; i++) begin m_sh[i] = 0; m_act[i] = 0; end
        e_code = 0; e_den = 0; e_blank = 1; e_fd = 0; e_ack = 0;
    endtask

    task automatic m_step();
        logic [4:0] sh_new [N];
        bit run_new, copy, lit;
        int p_new, slot;
        for (int i = 0; i < N; i++) sh_new[i] = m_sh[i];
        if (bus.wr_en && int'(bus.wr_idx) < N) sh_new[int'(bus.wr_idx)] = bus.wr_code;
        if (!enable) begin run_new = 0; p_new = 0; end
        else if (!m_run) begin run_new = 1; p_new = 0; end
        else begin run_new = 1; p_new = (m_p + 1) % F; end
        slot = p_new / (B + S);
        lit  = (p_new % (B + S)) >= B;
        copy = (run_new && p_new == F - 1 && (m_pend || bus.commit_req)) || (!m_run && m_pend);
        e_code  = run_new ? m_act[slot] : 5'd0;
        e_den   = (run_new && lit) ? N'(1 << slot) : '0;
        e_blank = !(run_new && lit);
        e_fd    = run_new && p_new == F - 1;
        e_ack   = copy;
        m_pend  = copy ? 1'b0 : (m_pend || bus.commit_req);
        for (int i = 0; i < N; i++) begin
            if (copy) m_act[i] = sh_new[i];
            m_sh[i] = sh_new[i];
        end
        m_run = run_new;
        m_p   = p_new;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("code_out", 32'(code_out), 32'(e_code));
            check("digit_en", 32'(digit_en), 32'(e_den));
            check("blank", 32'(blank), 32'(e_blank));
            check("frame_done", 32'(frame_done), 32'(e_fd));
            check("commit_ack", 32'(bus.commit_ack), 32'(e_ack));
        end
    end

    task automatic idle_bus();
        bus.wr_en = 0; bus.wr_idx = 0; bus.wr_code = 0; bus.commit_req = 0;
    endtask

    task automatic wait_den(input logic [N-1:0] v, input string name);
        int k;
        for (k = 0; k < 3 * F; k++) begin
            @(negedge clk);
            if (digit_en == v) break;
        end
        if (k == 3 * F) begin
            checks++; errors++;
            $display("FAIL %s: digit_en never reached %0h", name, v);
        end
    endtask

    task automatic write(input logic [2:0] idx, input logic [4:0] code);
        bus.wr_en = 1; bus.wr_idx = idx; bus.wr_code = code;
        @(negedge clk);
        idle_bus();
    endtask

    initial begin
        int fd_n, fd_t, acks, k;
        idle_bus();
        repeat (2) @(negedge clk);
        check("rst_den", 32'(digit_en), 0);
        check("rst_blank", 32'(blank), 1);
        rst_n = 1;
        @(negedge clk);

        // Scan timing from enable.
        enable = 1;
        fd_n = 0; fd_t = 0;
        for (int t = 1; t <= 45; t++) begin
            @(negedge clk);
            if (t == 2)  check("t2_blank", 32'(blank), 1);
            if (t == 3)  check("t3_den", 32'(digit_en), 1);
            if (t == 10) check("t10_den", 32'(digit_en), 1);
            if (t == 11) check("t11_blank", 32'(blank), 1);
            if (t == 13) check("t13_den", 32'(digit_en), 2);
            if (frame_done) begin fd_n++; fd_t = t; end
        end
        check("fd_count", 32'(fd_n), 1);
        check("fd_at", 32'(fd_t), 40);

        // Shadow writes then commit mid-frame.
        write(3'd0, 5'b10111);
        write(3'd1, 5'b11010);
        bus.commit_req = 1; @(negedge clk); idle_bus();
        for (k = 0; k < 2 * F; k++) begin
            if (bus.commit_ack) break;
            @(negedge clk);
        end
        check("ack_seen", 32'(bus.commit_ack), 1);
        check("ack_with_fd", 32'(frame_done), 1);
        wait_den(4'b0001, "d0_wait");
        check("d0_code", 32'(code_out), 32'(5'b10111));
        wait_den(4'b0010, "d1_wait");
        check("d1_code", 32'(code_out), 32'(5'b11010));

        // Out-of-range write still acks exactly once.
        write(3'd5, 5'b11111);
        bus.commit_req = 1; @(negedge clk); idle_bus();
        acks = 0;
        for (int t = 0; t < 2 * F + 4; t++) begin
            if (bus.commit_ack) acks++;
            @(negedge clk);
        end
        check("oor_acks", 32'(acks), 1);

        // Disable during digit 2 show, then restart.
        wait_den(4'b0100, "d2_wait");
        enable = 0;
        @(negedge clk);
        check("dis_den", 32'(digit_en), 0);
        check("dis_blank", 32'(blank), 1);
        check("dis_fd", 32'(frame_done), 0);
        enable = 1;
        @(negedge clk);
        @(negedge clk);
        check("re_blank", 32'(blank), 1);
        @(negedge clk);
        check("re_den", 32'(digit_en), 1);

        // Request and write sampled on the copy edge.
        for (k = 0; k < 2 * F; k++) begin
            if (m_run && m_p == F - 2) break;
            @(negedge clk);
        end
        check("edge_found", 32'(k < 2 * F), 1);
        bus.commit_req = 1; bus.wr_en = 1; bus.wr_idx = 3'd3; bus.wr_code = 5'b01001;
        @(negedge clk);
        idle_bus();
        check("t5_ack", 32'(bus.commit_ack), 1);
        check("t5_fd", 32'(frame_done), 1);
        acks = 0;
        for (k = 0; k < 2 * F; k++) begin
            @(negedge clk);
            if (bus.commit_ack) acks++;
            if (digit_en == 4'b1000) break;
        end
        check("t5_d3_code", 32'(code_out), 32'(5'b01001));
        check("t5_extra_acks", 32'(acks), 0);

        // Async reset mid-show with a commit pending.
        wait_den(4'b0001, "t6_wait");
        bus.commit_req = 1; @(negedge clk); idle_bus();
        #2 rst_n = 0;
        #1;
        check("ar_den", 32'(digit_en), 0);
        check("ar_blank", 32'(blank), 1);
        check("ar_code", 32'(code_out), 0);
        @(negedge clk);
        rst_n = 1;
        acks = 0;
        for (int t = 0; t < 2 * F; t++) begin
            @(negedge clk);
            if (bus.commit_ack) acks++;
        end
        check("ar_no_ack", 32'(acks), 0);

        // Randomized traffic.
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            bus.wr_en      = ($urandom_range(0, 2) == 0);
            bus.wr_idx     = 3'($urandom_range(0, 7));
            bus.wr_code    = 5'($urandom);
            bus.commit_req = ($urandom_range(0, 29) == 0);
            if (t == 1500) begin
                #3 rst_n = 0;
                @(negedge clk);
                rst_n = 1;
            end else begin
                @(negedge clk);
            end
        end
        idle_bus();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
